// File: rtl/TauCfg.sv
// Shared build-time sizes for the tile accumulation unit.
package TauCfg;
    localparam int N_ICFG         = 4;
    localparam int LOCAL_ADDR_BW0 = 10;
endpackage

// File: rtl/linear_alloc_scheduler_pkg.sv
// Types private to the linear SRAM allocation scheduler.
package linear_alloc_scheduler_pkg;
    // Bit positions of the one-hot scheduler state; FSM_N is the vector width.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FSM_N = 2'd3
    } fsm_e;
endpackage

// File: rtl/linear_ring_counter.sv
// Write pointer and occupancy of one circular SRAM region.
module linear_ring_counter #(
    parameter int LBW = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         clear,
    input  logic         alloc,
    input  logic         free,
    input  logic [LBW:0] size,
    input  logic [LBW:0] cap,
    output logic [LBW:0] ptr,
    output logic [LBW:0] used,
    output logic         has_room,
    output logic         can_free
);
    logic [LBW+1:0] room_sum;
    logic [LBW:0]   ptr_sum;
    logic [LBW:0]   ptr_nx;
    logic [LBW:0]   used_nx;

    assign room_sum = {1'b0, used} + {1'b0, size};
    assign has_room = (room_sum <= {1'b0, cap});
    assign can_free = (used >= size);

    // ptr < cap and size <= cap, so one conditional subtract is a full modulo.
    assign ptr_sum = ptr + size;
    assign ptr_nx  = (ptr_sum >= cap) ? (ptr_sum - cap) : ptr_sum;

    always_comb begin
        used_nx = used;
        if (alloc) used_nx = used_nx + size;
        if (free)  used_nx = used_nx - size;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ptr  <= '0;
            used <= '0;
        end else if (clear) begin
            ptr  <= '0;
            used <= '0;
        end else begin
            if (alloc) ptr <= ptr_nx;
            used <= used_nx;
        end
    end
endmodule

// File: rtl/linear_alloc_scheduler.sv
// Hands out ring-ordered block base addresses per config id and drains all
// regions before acknowledging end of tile.
module linear_alloc_scheduler
    import linear_alloc_scheduler_pkg::*;
#(
    parameter int LBW     = TauCfg::LOCAL_ADDR_BW0,
    parameter int N_ICFG  = TauCfg::N_ICFG,
    parameter int ICFG_BW = $clog2(N_ICFG + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               cfg_rdy,
    output logic               cfg_ack,
    input  logic [LBW-1:0]     i_bofs  [N_ICFG],
    input  logic [LBW:0]       i_cap   [N_ICFG],
    input  logic [LBW:0]       i_sizes [N_ICFG],
    input  logic               req_rdy,
    output logic               req_ack,
    input  logic [ICFG_BW-1:0] i_req_id,
    output logic               alloc_linear_rdy,
    input  logic               alloc_linear_ack,
    output logic [LBW-1:0]     o_linear,
    output logic [ICFG_BW-1:0] o_linear_id,
    input  logic               free_rdy,
    output logic               free_ack,
    input  logic [ICFG_BW-1:0] i_free_id,
    input  logic               end_rdy,
    output logic               end_ack,
    output logic               o_busy
);
    localparam int NST = FSM_N;
    localparam logic [NST-1:0] S_IDLE  = NST'(1) << IDLE;
    localparam logic [NST-1:0] S_RUN   = NST'(1) << RUN;
    localparam logic [NST-1:0] S_DRAIN = NST'(1) << DRAIN;

    logic [NST-1:0]    state_q, state_d;
    logic [LBW-1:0]    bofs_q [N_ICFG];
    logic [LBW:0]      cap_q  [N_ICFG];
    logic [LBW:0]      size_q [N_ICFG];
    logic [LBW:0]      ptr_w  [N_ICFG];
    logic [LBW:0]      used_w [N_ICFG];
    logic [N_ICFG-1:0] room_w, canfree_w, alloc_w, free_w;
    logic              req_room, free_ok, all_empty, busy_q;
    logic [LBW-1:0]    req_base;

    always_ff @(posedge i_clk) begin
        if (cfg_ack) begin
            for (int i = 0; i < N_ICFG; i++) begin
                bofs_q[i] <= i_bofs[i];
                cap_q[i]  <= i_cap[i];
                size_q[i] <= i_sizes[i];
            end
        end
    end

    always_comb begin
        req_room  = 1'b0;
        req_base  = '0;
        free_ok   = 1'b0;
        all_empty = 1'b1;
        for (int i = 0; i < N_ICFG; i++) begin
            if (i_req_id == ICFG_BW'(i)) begin
                req_room = room_w[i];
                req_base = LBW'(bofs_q[i] + ptr_w[i]);
            end
            if (i_free_id == ICFG_BW'(i)) free_ok = canfree_w[i];
            if (used_w[i] != '0) all_empty = 1'b0;
        end
    end

    assign req_ack  = state_q[RUN] && req_rdy && (!alloc_linear_rdy || alloc_linear_ack) && req_room;
    assign free_ack = (state_q[RUN] || state_q[DRAIN]) && free_rdy && free_ok;

    for (genvar g = 0; g < N_ICFG; g++) begin : g_ring
        assign alloc_w[g] = req_ack  && (i_req_id  == ICFG_BW'(g));
        assign free_w[g]  = free_ack && (i_free_id == ICFG_BW'(g));

        linear_ring_counter #(.LBW(LBW)) u_ring (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .clear    (cfg_ack),
            .alloc    (alloc_w[g]),
            .free     (free_w[g]),
            .size     (size_q[g]),
            .cap      (cap_q[g]),
            .ptr      (ptr_w[g]),
            .used     (used_w[g]),
            .has_room (room_w[g]),
            .can_free (canfree_w[g])
        );
    end

    always_comb begin
        state_d = state_q;
        cfg_ack = 1'b0;
        end_ack = 1'b0;
        if (state_q[IDLE]) begin
            cfg_ack = cfg_rdy;
            if (cfg_rdy) state_d = S_RUN;
        end else if (state_q[RUN]) begin
            if (end_rdy) state_d = S_DRAIN;
        end else if (state_q[DRAIN]) begin
            // Tile may end only once every region and the output slot are empty.
            if (all_empty && !alloc_linear_rdy) begin
                end_ack = end_rdy;
                if (end_rdy) state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q          <= S_IDLE;
            busy_q           <= 1'b0;
            alloc_linear_rdy <= 1'b0;
            o_linear         <= '0;
            o_linear_id      <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= !state_d[IDLE];
            if (req_ack) begin
                alloc_linear_rdy <= 1'b1;
                o_linear         <= req_base;
                o_linear_id      <= i_req_id;
            end else if (alloc_linear_ack) begin
                alloc_linear_rdy <= 1'b0;
            end
        end
    end

    assign o_busy = busy_q;
endmodule

// File: tb/tb_linear_alloc_scheduler.sv
// Randomized and directed bench for linear_alloc_scheduler against a
// count-based model of each circular region.
module tb_linear_alloc_scheduler;
    localparam int LBW = 10;
    localparam int N   = 4;
    localparam int IW  = 3;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          cfg_rdy = 1'b0, req_rdy = 1'b0, free_rdy = 1'b0, end_rdy = 1'b0;
    logic          alloc_linear_ack = 1'b0;
    logic [IW-1:0] i_req_id = '0, i_free_id = '0;
    logic [LBW-1:0] bofs_in [N];
    logic [LBW:0]   cap_in  [N];
    logic [LBW:0]   size_in [N];
    logic          cfg_ack, req_ack, free_ack, end_ack, alloc_linear_rdy, o_busy;
    logic [LBW-1:0] o_linear;
    logic [IW-1:0]  o_linear_id;

    int checks = 0;
    int errors = 0;

    int m_bofs [N], m_cap [N], m_size [N], m_na [N], m_nf [N];
    int m_mode;
    bit m_ovld;
    int m_olin, m_oid;
    bit last_req, last_free, last_end;

    always #5 i_clk = ~i_clk;

    linear_alloc_scheduler #(.LBW(LBW), .N_ICFG(N), .ICFG_BW(IW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .cfg_rdy(cfg_rdy), .cfg_ack(cfg_ack),
        .i_bofs(bofs_in), .i_cap(cap_in), .i_sizes(size_in),
        .req_rdy(req_rdy), .req_ack(req_ack), .i_req_id(i_req_id),
        .alloc_linear_rdy(alloc_linear_rdy), .alloc_linear_ack(alloc_linear_ack),
        .o_linear(o_linear), .o_linear_id(o_linear_id),
        .free_rdy(free_rdy), .free_ack(free_ack), .i_free_id(i_free_id),
        .end_rdy(end_rdy), .end_ack(end_ack), .o_busy(o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_used(input int id);
        return (m_na[id] - m_nf[id]) * m_size[id];
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ovld = 0; m_olin = 0; m_oid = 0;
        last_req = 0; last_free = 0; last_end = 0;
    endtask

    // One clock: compare at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        bit e_cfg, e_req, e_free, e_end, empty;
        int rid, fid;
        @(negedge i_clk);
        rid = int'(i_req_id);
        fid = int'(i_free_id);
        empty = 1;
        for (int i = 0; i < N; i++) if (m_used(i) != 0) empty = 0;
        e_cfg  = (m_mode == 0) && cfg_rdy;
        e_req  = (m_mode == 1) && req_rdy && (!m_ovld || alloc_linear_ack)
                 && (m_used(rid) + m_size[rid] <= m_cap[rid]);
        e_free = (m_mode != 0) && free_rdy && (m_used(fid) >= m_size[fid]);
        e_end  = (m_mode == 2) && end_rdy && empty && !m_ovld;
        chk("cfg_ack", cfg_ack, e_cfg);
        chk("req_ack", req_ack, e_req);
        chk("free_ack", free_ack, e_free);
        chk("end_ack", end_ack, e_end);
        chk("busy", o_busy, m_mode != 0);
        chk("alloc_rdy", alloc_linear_rdy, m_ovld);
        chk("o_linear", o_linear, m_olin);
        chk("o_linear_id", o_linear_id, m_oid);
        last_req = e_req; last_free = e_free; last_end = e_end;
        @(posedge i_clk);
        if (e_cfg) begin
            for (int i = 0; i < N; i++) begin
                m_bofs[i] = int'(bofs_in[i]);
                m_cap[i]  = int'(cap_in[i]);
                m_size[i] = int'(size_in[i]);
                m_na[i] = 0; m_nf[i] = 0;
            end
            m_mode = 1;
        end
        if (e_req) begin
            m_ovld = 1;
            m_olin = m_bofs[rid] + (m_na[rid] * m_size[rid]) % m_cap[rid];
            m_oid  = rid;
            m_na[rid]++;
        end else if (m_ovld && alloc_linear_ack) begin
            m_ovld = 0;
        end
        if (e_free) m_nf[fid]++;
        if (m_mode == 1 && end_rdy) m_mode = 2;
        else if (e_end) m_mode = 0;
        #1;
    endtask

    task automatic set_region(input int id, input int b, input int c, input int s);
        bofs_in[id] = LBW'(b);
        cap_in[id]  = (LBW+1)'(c);
        size_in[id] = (LBW+1)'(s);
    endtask

    task automatic cfg_default();
        set_region(0, 256, 96, 32);
        set_region(1, 128, 64, 32);
        set_region(2, 512, 200, 24);
        set_region(3, 900, 124, 7);
    endtask

    task automatic do_cfg();
        cfg_rdy = 1; tick(); cfg_rdy = 0;
    endtask

    task automatic pulse_req(input int id, input int n);
        req_rdy = 1; i_req_id = IW'(id);
        repeat (n) tick();
        req_rdy = 0;
    endtask

    task automatic pulse_free(input int id, input int n);
        free_rdy = 1; i_free_id = IW'(id);
        repeat (n) tick();
        free_rdy = 0;
    endtask

    // Random traffic obeying the sender hold rule; frees only target ids with blocks out.
    task automatic rand_stim(input bit allow_req);
        int q[$];
        if (!(req_rdy && !last_req)) begin
            req_rdy  = allow_req && ($urandom_range(0, 2) != 0);
            i_req_id = IW'($urandom_range(0, N-1));
        end
        if (!(free_rdy && !last_free)) begin
            q.delete();
            for (int i = 0; i < N; i++) if (m_used(i) > 0) q.push_back(i);
            free_rdy = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            if (q.size() > 0) i_free_id = IW'(q[$urandom_range(0, q.size()-1)]);
        end
        alloc_linear_ack = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain_all();
        int n;
        req_rdy = 0; end_rdy = 1; n = 0;
        while (!last_end && n < 600) begin
            rand_stim(0);
            tick();
            n++;
        end
        chk("drain_done", last_end, 1);
        end_rdy = 0; free_rdy = 0;
        tick();
        chk("drain_idle", o_busy, 0);
    endtask

    initial begin
        int want [4];
        want[0] = 256; want[1] = 288; want[2] = 320; want[3] = 256;
        cfg_default();
        model_reset();
        for (int i = 0; i < N; i++) begin
            m_bofs[i] = 0; m_cap[i] = 1; m_size[i] = 1; m_na[i] = 0; m_nf[i] = 0;
        end

        #12;
        chk("rst_rdy", alloc_linear_rdy, 0);
        chk("rst_lin", o_linear, 0);
        chk("rst_id", o_linear_id, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_acks", {cfg_ack, req_ack, free_ack, end_ack}, 0);
        i_rst = 1;
        @(posedge i_clk); #1;

        do_cfg();
        alloc_linear_ack = 1;

        for (int k = 0; k < 4; k++) begin
            pulse_req(0, 1);
            chk("wrap_lin", o_linear, want[k]);
            pulse_free(0, 1);
        end

        pulse_req(1, 2);
        req_rdy = 1; i_req_id = 1;
        tick();
        chk("stall_hold", req_ack, 0);
        free_rdy = 1; i_free_id = 1;
        tick();
        free_rdy = 0;
        tick();
        req_rdy = 0;
        chk("stall_lin", o_linear, 128);
        pulse_free(1, 2);

        alloc_linear_ack = 0;
        pulse_req(2, 1);
        req_rdy = 1; i_req_id = 2;
        repeat (5) begin
            tick();
            chk("bp_lin", o_linear, 512);
        end
        alloc_linear_ack = 1;
        repeat (3) tick();
        req_rdy = 0;
        tick();
        chk("bp_last", o_linear, 584);
        pulse_free(2, 4);

        pulse_req(1, 1);
        req_rdy = 1; i_req_id = 1; free_rdy = 1; i_free_id = 1;
        tick();
        free_rdy = 0;
        tick();
        req_rdy = 1; free_rdy = 1;
        tick();
        free_rdy = 0;
        tick();
        req_rdy = 0;
        pulse_free(1, 2);
        pulse_free(3, 4);
        chk("free_empty", free_ack, 0);

        pulse_req(0, 2);
        end_rdy = 1;
        tick();
        req_rdy = 1; i_req_id = 2;
        repeat (3) tick();
        pulse_free(0, 2);
        tick();
        chk("drain_end", last_end, 1);
        end_rdy = 0;
        tick();
        req_rdy = 0;
        chk("drain_busy", o_busy, 0);

        do_cfg();
        alloc_linear_ack = 0;
        pulse_req(3, 1);
        tick();
        #2 i_rst = 0;
        #1;
        chk("mid_rdy", alloc_linear_rdy, 0);
        chk("mid_lin", o_linear, 0);
        chk("mid_id", o_linear_id, 0);
        chk("mid_busy", o_busy, 0);
        model_reset();
        req_rdy = 0; free_rdy = 0; end_rdy = 0; cfg_rdy = 0;
        @(negedge i_clk); #1 i_rst = 1;
        @(posedge i_clk); #1;
        do_cfg();
        alloc_linear_ack = 1;
        pulse_req(3, 1);
        chk("mid_first", o_linear, 900);
        drain_all();

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                int c, s, b;
                c = $urandom_range(1, 256);
                s = $urandom_range(1, c / 3 + 1);
                b = $urandom_range(0, 1024 - c);
                set_region(i, b, c, s);
            end
            do_cfg();
            repeat (300) begin
                rand_stim(1);
                tick();
            end
            drain_all();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
